// File: rtl/aes_enc_ctrl_pkg.sv
// Shared types and GF(2^8) helpers for the iterative AES-128 encryption datapath.
// The state is column-major: byte i lives in column i/4, row i%4, and byte 0 is the MSB.
package aes_enc_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRound,
    StDone
  } aes_fsm_e;

  localparam int unsigned AesNr = 10;

  function automatic logic [7:0] xtime(logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One MixColumns column, row 0 in the top byte.
  function automatic logic [31:0] mix_column(logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic int unsigned byte_idx(int unsigned col, int unsigned row);
    return 4 * col + row;
  endfunction

  function automatic logic [7:0] get_byte(logic [127:0] s, int unsigned idx);
    return s[8 * (15 - idx) +: 8];
  endfunction

endpackage

// File: rtl/aes_enc_ctrl_if.sv
// Block-level handshake bundle: plaintext/key in, ciphertext out.
interface aes_enc_ctrl_if;

  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_block;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_block;

  modport master (
    output in_valid, in_block, in_key, out_ready,
    input  in_ready, out_valid, out_block
  );

  modport slave (
    input  in_valid, in_block, in_key, out_ready,
    output in_ready, out_valid, out_block
  );

endinterface

// File: rtl/aes_round_comb.sv
// One full AES round (SubBytes, ShiftRows, optional MixColumns, AddRoundKey), purely
// combinational.
module aes_round_comb
  import aes_enc_ctrl_pkg::*;
(
  input  logic [127:0] state_in_i,
  input  logic [127:0] rkey_i,
  input  logic         final_i,
  output logic [127:0] state_out_o
);

  logic [7:0] sb [16];
  logic [7:0] sr [16];

  for (genvar i = 0; i < 16; i++) begin : g_sbox
    aes_sbox u_sbox (
      .in_i  (get_byte(state_in_i, i)),
      .out_o (sb[i])
    );
  end

  // Row r rotates left by r columns.
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[byte_idx(c, r)] = sb[byte_idx((c + r) % 4, r)];
      end
    end
  end

  always_comb begin
    logic [31:0] col;
    col         = '0;
    state_out_o = '0;
    for (int c = 0; c < 4; c++) begin
      col = {sr[byte_idx(c, 0)], sr[byte_idx(c, 1)], sr[byte_idx(c, 2)], sr[byte_idx(c, 3)]};
      if (!final_i) begin
        col = mix_column(col);
      end
      state_out_o[32 * (3 - c) +: 32] = col ^ rkey_i[32 * (3 - c) +: 32];
    end
  end

endmodule

// File: rtl/aes_sbox.sv
// AES forward S-box as a constant lookup table.
module aes_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  // Entry 0x00 occupies the top byte, so the table reads in natural order.
  localparam logic [2047:0] SboxTable = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [7:0] rev_idx;

  assign rev_idx = 8'hff - in_i;
  assign out_o   = SboxTable[{rev_idx, 3'b000} +: 8];

endmodule

// File: rtl/key_expansion.sv
// AES-128 round-key generator: each enabled cycle registers the next round key, starting
// from the cipher key when round_i is 0.
module key_expansion (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic [3:0]   round_i,
  input  logic [127:0] cipher_key_i,
  output logic [127:0] round_key_o
);

  logic [127:0] round_key_q, round_key_d, base;
  logic [31:0]  rot, sub, t, w0, w1, w2, w3;
  logic [7:0]   rcon;

  assign base = (round_i == 4'd0) ? cipher_key_i : round_key_q;
  assign rot  = {base[23:0], base[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (
      .in_i  (rot[8 * i +: 8]),
      .out_o (sub[8 * i +: 8])
    );
  end

  // Produces K(round_i + 1), so the constant is indexed one ahead of round_i.
  always_comb begin
    rcon = 8'h00;
    case (round_i + 4'd1)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign t           = sub ^ {rcon, 24'h000000};
  assign w0          = base[127:96] ^ t;
  assign w1          = base[95:64] ^ w0;
  assign w2          = base[63:32] ^ w1;
  assign w3          = base[31:0] ^ w2;
  assign round_key_d = {w0, w1, w2, w3};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      round_key_q <= '0;
    end else if (en_i) begin
      round_key_q <= round_key_d;
    end
  end

  assign round_key_o = round_key_q;

endmodule

// File: rtl/aes_enc_ctrl.sv
// Iterative AES-128 encryption controller: owns the cipher state, the round sequencer and the
// in/out handshakes, and steps the external key expander one round key per cycle.
module aes_enc_ctrl
  import aes_enc_ctrl_pkg::*;
#(
  parameter int unsigned Nr = AesNr
) (
  input  logic          clk,
  input  logic          rst_n,
  aes_enc_ctrl_if.slave blk_if,
  output logic          ke_en_o,
  output logic [3:0]    ke_round_o,
  output logic [127:0]  ke_cipher_key_o,
  input  logic [127:0]  ke_round_key_i,
  output logic          busy_o
);

  localparam logic [3:0] LastRnd = 4'(Nr);

  aes_fsm_e     fsm_q, fsm_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] state_q, state_d;
  logic [127:0] round_out;
  logic         in_ready;
  logic         accept;

  aes_round_comb u_round (
    .state_in_i  (state_q),
    .rkey_i      (ke_round_key_i),
    .final_i     (rnd_q == LastRnd),
    .state_out_o (round_out)
  );

  assign in_ready         = (fsm_q == StIdle) | ((fsm_q == StDone) & blk_if.out_ready);
  assign accept           = blk_if.in_valid & in_ready;
  assign blk_if.in_ready  = in_ready;
  assign blk_if.out_valid = (fsm_q == StDone);
  assign blk_if.out_block = state_q;
  assign busy_o           = (fsm_q == StRound);
  assign ke_cipher_key_o  = blk_if.in_key;

  always_comb begin
    fsm_d      = fsm_q;
    rnd_d      = rnd_q;
    state_d    = state_q;
    ke_en_o    = 1'b0;
    ke_round_o = 4'd0;

    unique case (fsm_q)
      StIdle: begin
      end
      StRound: begin
        state_d    = round_out;
        ke_en_o    = (rnd_q < LastRnd);
        ke_round_o = rnd_q;
        if (rnd_q == LastRnd) begin
          fsm_d = StDone;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      StDone: begin
        if (blk_if.out_ready) begin
          fsm_d = StIdle;
        end
      end
      default: fsm_d = StIdle;
    endcase

    // An accept in DONE overrides the return to IDLE, giving the back-to-back handoff.
    if (accept) begin
      state_d    = blk_if.in_block ^ blk_if.in_key;
      rnd_d      = 4'd1;
      fsm_d      = StRound;
      ke_en_o    = 1'b1;
      ke_round_o = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= StIdle;
      rnd_q   <= 4'd0;
      state_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      rnd_q   <= rnd_d;
      state_q <= state_d;
    end
  end

endmodule

// File: doc/aes_enc_ctrl.md
# aes_enc_ctrl

Iterative AES-128 encryption engine controller. It owns the 128-bit cipher state register and the round sequencer, and drives the existing `key_expansion` block (`ke_*` ports) one round key per cycle. Plaintext and key enter over a valid/ready handshake, and ciphertext leaves over a second one. It sits between the bus-side block buffer and the key expander, with one block in flight at a time.

## Interface
Parameters:
- `NR`, default 10: number of rounds. Fixed at 10 for AES-128; other values are unsupported.

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `in_valid`  in  1  plaintext/key offered
- `in_ready`  out  1  block can accept
- `in_block`  in  128  plaintext, FIPS-197 byte 0 in [127:120]
- `in_key`  in  128  cipher key, same byte order
- `out_valid`  out  1  ciphertext available
- `out_ready`  in  1  consumer takes ciphertext
- `out_block`  out  128  ciphertext (equals state register)
- `ke_en`  out  1  key expander update enable
- `ke_round`  out  4  key expander round index
- `ke_cipher_key`  out  128  key expander cipher_key input
- `ke_round_key`  in  128  key expander round_key (its internal register)
- `busy`  out  1  high in ROUND

## Operation
- FSM states: IDLE, ROUND, DONE. Round counter `rnd` is 4 bits, range 1..NR.
- Accept: `in_valid & in_ready` is the accept event (cycle A).
  - At the edge: `state <= in_block ^ in_key`, `rnd <= 1`, FSM goes to ROUND.
  - Same cycle, combinationally: `ke_en=1`, `ke_round=0`, `ke_cipher_key=in_key`. The expander therefore loads K1.
- ROUND, each cycle: `state <= round_fn(state, ke_round_key, final=(rnd==NR))`.
  - `round_fn` is SubBytes, then ShiftRows, then MixColumns (omitted when final), then XOR with round key.
  - `ke_en = (rnd < NR)` and `ke_round = rnd`, so K(rnd+1) is ready next cycle.
  - `rnd` increments. When `rnd==NR`, FSM goes to DONE.
- DONE: `out_valid=1` and `out_block` is held stable until `out_ready`.
  - On `out_valid & out_ready`, FSM goes to IDLE, unless a new accept happens the same cycle (see below).
- `in_ready = (fsm==IDLE) | (fsm==DONE & out_ready)`.
  - Simultaneous handoff in DONE: output consumed and new block accepted on the same edge; FSM goes DONE to ROUND directly.
- Outside accept cycles: `ke_en=0`, `ke_round` is 0 in IDLE/DONE, and `ke_cipher_key=in_key` (passthrough, don't-care).
- `in_block` and `in_key` are sampled only in the accept cycle; later changes have no effect.
- `in_valid` while ROUND is ignored (`in_ready=0`). The producer must hold `in_valid` and its data until accepted.

## Timing
- Reset values: FSM=IDLE, `state=0`, `rnd=0`, `in_ready=1`, `out_valid=0`, `out_block=0`, `ke_en=0`, `ke_round=0`, `busy=0`.
- Latency: accept edge E0, then rounds on E1..E10. `out_valid` rises in the cycle after E10, which is 11 cycles after the accept cycle.
- Throughput: one block per 11 cycles with `out_ready` tied high (back-to-back via the DONE handoff).
- `out_valid` never drops without `out_ready`. `out_block` is constant while `out_valid & !out_ready`.
- Reset mid-operation: everything returns to reset values immediately (async). The partial block is discarded, with no output.
- `ke_round_key` is assumed valid from the expander's registered output, one cycle after `ke_en`. No other timing path to the expander exists.

## Structure
- Package `aes_pkg`:
  - FSM state enum (IDLE/ROUND/DONE)
  - `AES_NR=10`
  - `xtime` and MixColumns column functions
  - byte-index helpers for the column-major state layout
- Sub-module `aes_round_comb`: combinational, ports `state_in[127:0]`, `rkey[127:0]`, `final`, `state_out[127:0]`. It instantiates 16 `aes_sbox`.
- The controller holds the FSM, `rnd`, the state register and the handshake logic only.

## Test plan
Bench instantiates `aes_enc_ctrl` plus `key_expansion`, wired through `ke_*`.
- FIPS-197 C.1 vector:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff.
  - Response: `out_block`=69c4e0d86a7b0430d8cdb78070b4c55a, with `out_valid` 11 cycles after accept.
- FIPS-197 B vector:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734.
  - Response: ct 3925841d02dc09fbdc118597196a0b32.
- Backpressure:
  - Stimulus: hold `out_ready=0` for 20 cycles after `out_valid`.
  - Response: `out_block` stable, `in_ready=0`, and a new `in_valid` is not accepted.
- Back-to-back:
  - Stimulus: `out_ready=1` throughout, two blocks (C.1 then B) offered continuously.
  - Response: second accept lands on the DONE cycle of the first, and both ciphertexts are correct.
- Mid-operation reset:
  - Stimulus: assert `rst_n=0` at round 5, release, then run C.1.
  - Response: all outputs at reset values during reset, no spurious `out_valid`, and the next result is correct.
